// File: rtl/button_scan_ctrl_if.sv
// Event handshake between the button scanner (master) and its consumer (slave).
// evt_code carries the index of the button at the head of the event FIFO.
interface button_scan_ctrl_if #(
  parameter int N_BTN = 4
);
  localparam int CODE_W = $clog2(N_BTN);

  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/button_scan_ctrl.sv
// Round-robin debouncer: one shared up/down integrator visits one button per clock, press events queue in a FIFO.
// Define BTN_REPEAT_EN to add an auto-repeat timer for the most recently pressed button.
module button_scan_ctrl #(
  parameter int N_BTN      = 4,
  parameter int CNT_W      = 18,
  parameter int THRESH     = 24000,
  parameter int CNT_MAX    = 25000,
  parameter int FIFO_DEPTH = 4
`ifdef BTN_REPEAT_EN
  ,
  parameter int RPT_DLY    = 1000,
  parameter int RPT_PER    = 250
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_BTN-1:0]    i_btn_in,
  input  logic                i_scan_en,
  button_scan_ctrl_if.master  evt_if,
  output logic [N_BTN-1:0]    o_btn_state,
  output logic                o_ovf,
  input  logic                i_ovf_clr
);
  // state | meaning
  // IDLE  | scan frozen; idx and counters hold
  // SCAN  | one button visited per clock while scan_en=1

  localparam int IDX_W = $clog2(N_BTN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] C_THR_M1 = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [PTR_W:0]   C_DEPTH  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_visit;

  logic [N_BTN-1:0]  r_sync1;
  logic [N_BTN-1:0]  r_sync2;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt [N_BTN];
  logic [N_BTN-1:0]  r_btn_state;
  logic              r_ovf;
  logic [IDX_W-1:0]  r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;

  logic [CNT_W-1:0]  w_cnt_cur;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_sync_cur;
  logic              w_press;
  logic              w_release;
  logic              w_push;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_wr_en;
  logic              w_drop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_scan_en)  w_state_nxt = S_SCAN;
      S_SCAN:  if (!i_scan_en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The cycle that drops scan_en leaves SCAN without visiting anyone.
  always_comb begin
    w_visit = 1'b0;
    case (r_state)
      S_SCAN:  w_visit = i_scan_en;
      default: w_visit = 1'b0;
    endcase
  end

  always_comb begin
    w_cnt_cur  = r_cnt[r_idx];
    w_sync_cur = r_sync2[r_idx];
    w_cnt_nxt  = w_cnt_cur;
    if (w_sync_cur && (w_cnt_cur < C_MAX))
      w_cnt_nxt = w_cnt_cur + C_ONE;
    else if (!w_sync_cur && (w_cnt_cur != '0))
      w_cnt_nxt = w_cnt_cur - C_ONE;
  end

  // btn_state doubles as the re-arm lock: it only clears once the counter is back at 0.
  assign w_press   = w_visit && w_sync_cur && (w_cnt_cur == C_THR_M1) && !r_btn_state[r_idx];
  assign w_release = w_visit && !w_sync_cur && (w_cnt_cur == C_ONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_btn_state <= '0;
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
    end else if (w_visit) begin
      r_cnt[r_idx] <= w_cnt_nxt;
      r_idx        <= r_idx + IDX_W'(1);
      if (w_press)        r_btn_state[r_idx] <= 1'b1;
      else if (w_release) r_btn_state[r_idx] <= 1'b0;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAXV = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RPT_W    = $clog2(RPT_MAXV + 1);

  logic              r_rpt_act;
  logic              r_rpt_first;
  logic [IDX_W-1:0]  r_rpt_idx;
  logic [RPT_W-1:0]  r_rpt_cnt;
  logic              w_rpt_own;
  logic              w_rpt_hit;
  logic              w_rpt_fire;
  logic [RPT_W-1:0]  w_rpt_inc;
  logic [RPT_W-1:0]  w_rpt_tgt;

  // Only visits that find the tracked button already saturated and still held advance the timer.
  assign w_rpt_own  = w_visit && r_rpt_act && (r_idx == r_rpt_idx);
  assign w_rpt_hit  = w_rpt_own && w_sync_cur && (w_cnt_cur == C_MAX);
  assign w_rpt_inc  = r_rpt_cnt + RPT_W'(1);
  assign w_rpt_tgt  = r_rpt_first ? RPT_W'(RPT_DLY) : RPT_W'(RPT_PER);
  assign w_rpt_fire = w_rpt_hit && (w_rpt_inc == w_rpt_tgt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rpt_act   <= 1'b0;
      r_rpt_first <= 1'b1;
      r_rpt_idx   <= '0;
      r_rpt_cnt   <= '0;
    end else if (w_press) begin
      r_rpt_act   <= 1'b1;
      r_rpt_first <= 1'b1;
      r_rpt_idx   <= r_idx;
      r_rpt_cnt   <= '0;
    end else if (w_rpt_own) begin
      if (w_rpt_fire) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b0;
      end else if (w_rpt_hit) begin
        r_rpt_cnt   <= w_rpt_inc;
      end else begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b1;
      end
    end
  end

  assign w_push = w_press || w_rpt_fire;
`else
  assign w_push = w_press;
`endif

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = ((r_wr_ptr - r_rd_ptr) == C_DEPTH);
  assign w_pop   = !w_empty && evt_if.evt_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_wr_en) begin
        r_fifo[r_wr_ptr[PTR_W-1:0]] <= r_idx;
        r_wr_ptr                    <= r_wr_ptr + (PTR_W + 1)'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (i_ovf_clr) r_ovf <= 1'b0;
  end

  assign evt_if.evt_valid = !w_empty;
  assign evt_if.evt_code  = w_empty ? '0 : r_fifo[r_rd_ptr[PTR_W-1:0]];
  assign o_btn_state      = r_btn_state;
  assign o_ovf            = r_ovf;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Bench for button_scan_ctrl: queue-based reference model checked every cycle plus directed scenarios.
// Repeat scenario is compiled in when BTN_REPEAT_EN is defined.
module tb_button_scan_ctrl;
  localparam int N_BTN      = 4;
  localparam int CNT_W      = 4;
  localparam int THRESH     = 6;
  localparam int CNT_MAX    = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef BTN_REPEAT_EN
  localparam int RPT_DLY    = 3;
  localparam int RPT_PER    = 2;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [3:0] btn_in  = 4'b0000;
  logic       scan_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] btn_state;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  button_scan_ctrl_if #(.N_BTN(N_BTN)) evt_if ();

  button_scan_ctrl #(
    .N_BTN      (N_BTN),
    .CNT_W      (CNT_W),
    .THRESH     (THRESH),
    .CNT_MAX    (CNT_MAX),
    .FIFO_DEPTH (FIFO_DEPTH)
`ifdef BTN_REPEAT_EN
    ,
    .RPT_DLY    (RPT_DLY),
    .RPT_PER    (RPT_PER)
`endif
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn_in    (btn_in),
    .i_scan_en   (scan_en),
    .evt_if      (evt_if),
    .o_btn_state (btn_state),
    .o_ovf       (ovf),
    .i_ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-button integer counters, a queue for the FIFO, visit order by plain modulo.
  int         m_cnt [N_BTN];
  logic [3:0] m_lvl = 4'b0000;
  int         m_q [$];
  bit         m_ovf = 1'b0;
  bit         m_run = 1'b0;
  int         m_idx = 0;
  logic [3:0] m_s1  = 4'b0000;
  logic [3:0] m_s2  = 4'b0000;
`ifdef BTN_REPEAT_EN
  int         m_rbtn   = -1;
  int         m_rn     = 0;
  bit         m_rfirst = 1'b1;
`endif

  initial begin
    int i, old;
    bit s, ev, pop;
    for (int k = 0; k < N_BTN; k++) m_cnt[k] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < N_BTN; k++) m_cnt[k] = 0;
        m_lvl = 4'b0000; m_q.delete(); m_ovf = 1'b0; m_run = 1'b0; m_idx = 0;
        m_s1 = 4'b0000; m_s2 = 4'b0000;
`ifdef BTN_REPEAT_EN
        m_rbtn = -1; m_rn = 0; m_rfirst = 1'b1;
`endif
      end else begin
        pop = (m_q.size() > 0) && (evt_if.evt_ready == 1'b1);
        ev  = 1'b0;
        i   = m_idx;
        if (m_run && scan_en) begin
          s   = m_s2[i];
          old = m_cnt[i];
          if (s && old < CNT_MAX)       m_cnt[i] = old + 1;
          else if (!s && old > 0)       m_cnt[i] = old - 1;
          if (s && old == THRESH - 1 && !m_lvl[i]) begin
            ev = 1'b1;
            m_lvl[i] = 1'b1;
`ifdef BTN_REPEAT_EN
            m_rbtn = i; m_rn = 0; m_rfirst = 1'b1;
`endif
          end
`ifdef BTN_REPEAT_EN
          else if (i == m_rbtn) begin
            if (s && old == CNT_MAX) begin
              m_rn++;
              if (m_rn == (m_rfirst ? RPT_DLY : RPT_PER)) begin
                ev = 1'b1; m_rn = 0; m_rfirst = 1'b0;
              end
            end else begin
              m_rn = 0; m_rfirst = 1'b1;
            end
          end
`endif
          if (m_cnt[i] == 0) m_lvl[i] = 1'b0;
          m_idx = (m_idx + 1) % N_BTN;
        end
        m_run = scan_en;
        if (pop) void'(m_q.pop_front());
        if (ev && m_q.size() >= FIFO_DEPTH) m_ovf = 1'b1;
        else begin
          if (ev) m_q.push_back(i);
          if (ovf_clr) m_ovf = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_valid", int'(evt_if.evt_valid), (m_q.size() > 0) ? 1 : 0);
        if (m_q.size() > 0) chk("cyc_code", int'(evt_if.evt_code), m_q[0]);
        chk("cyc_btn_state", int'(btn_state), int'(m_lvl));
        chk("cyc_ovf", int'(ovf), int'(m_ovf));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic goto(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic do_reset(input logic [3:0] b);
    rst_n = 1'b0; btn_in = b; scan_en = 1'b1; evt_if.evt_ready = 1'b0; ovf_clr = 1'b0;
    step(2);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic pop_one();
    evt_if.evt_ready = 1'b1;
    step(1);
    evt_if.evt_ready = 1'b0;
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;

    // Hold button 2 from reset release.
    do_reset(4'b0100);
    chk("rst_valid", int'(evt_if.evt_valid), 0);
    chk("rst_code",  int'(evt_if.evt_code), 0);
    chk("rst_state", int'(btn_state), 0);
    chk("rst_ovf",   int'(ovf), 0);
    while (!evt_if.evt_valid && cyc < 28) step(1);
    chk("t1_valid_by_28", int'(evt_if.evt_valid), 1);
    chk("t1_first_cycle", cyc, 24);
    chk("t1_code", int'(evt_if.evt_code), 2);
    goto(70);
    chk("t1_state", int'(btn_state), 4'b0100);
    chk("t1_model_depth", m_q.size(), 1);
    pop_one();
    chk("t1_single_event", int'(evt_if.evt_valid), 0);

    // Bounce on button 1 with a phase that never lets the counter climb past 1.
    do_reset(4'b0000);
    for (int t = 0; t < 200; t++) begin
      btn_in[1] = ((t / 3) % 2) == 1;
      step(1);
    end
    chk("t2_no_event", int'(evt_if.evt_valid), 0);
    chk("t2_state1", int'(btn_state[1]), 0);

    // All four pressed in scan order, then an overflowing fifth event.
    do_reset(4'b0000);
    goto(3);
    btn_in = 4'b1111;
    goto(33);
    chk("t3_valid", int'(evt_if.evt_valid), 1);
    chk("t3_head", int'(evt_if.evt_code), 0);
    chk("t3_ovf0", int'(ovf), 0);
    chk("t3_model_depth", m_q.size(), 4);
    btn_in = 4'b0000;
    goto(90);
    chk("t3_released", int'(btn_state), 0);
    btn_in = 4'b0001;
    goto(120);
    chk("t3_ovf_set", int'(ovf), 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", int'(ovf), 0);
    for (int k = 0; k < 4; k++) begin
      chk("t3_order", int'(evt_if.evt_code), k);
      pop_one();
    end
    chk("t3_drained", int'(evt_if.evt_valid), 0);

    // Full FIFO with a pop on the same edge as a new push.
    do_reset(4'b0000);
    goto(3);
    btn_in = 4'b1111;
    goto(35);
    btn_in = 4'b1110;
    goto(67);
    btn_in = 4'b1111;
    goto(89);
    chk("t4_head_pre", int'(evt_if.evt_code), 0);
    chk("t4_ovf_pre", int'(ovf), 0);
    pop_one();
    chk("t4_ovf_post", int'(ovf), 0);
    chk("t4_state", int'(btn_state), 4'b1111);
    for (int k = 0; k < 4; k++) begin
      chk("t4_order", int'(evt_if.evt_code), (k + 1) % 4);
      chk("t4_valid", int'(evt_if.evt_valid), 1);
      pop_one();
    end
    chk("t4_drained", int'(evt_if.evt_valid), 0);

    // Freeze the scan mid-press, resume, then reset with an event pending.
    do_reset(4'b0000);
    goto(3);
    btn_in = 4'b0001;
    goto(15);
    scan_en = 1'b0;
    goto(65);
    chk("t5_frozen_valid", int'(evt_if.evt_valid), 0);
    chk("t5_frozen_state", int'(btn_state), 0);
    scan_en = 1'b1;
    goto(76);
    chk("t5_before_evt", int'(evt_if.evt_valid), 0);
    step(1);
    chk("t5_evt_valid", int'(evt_if.evt_valid), 1);
    chk("t5_evt_code", int'(evt_if.evt_code), 0);
    chk("t5_state", int'(btn_state), 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(evt_if.evt_valid), 0);
    chk("t5_rst_state", int'(btn_state), 0);

`ifdef BTN_REPEAT_EN
    // Auto-repeat on button 3: press at 29, repeats at 49 and 57.
    do_reset(4'b0000);
    goto(3);
    btn_in = 4'b1000;
    goto(29);
    chk("t6_press", int'(evt_if.evt_valid), 1);
    chk("t6_press_code", int'(evt_if.evt_code), 3);
    pop_one();
    goto(48);
    chk("t6_no_rpt_yet", int'(evt_if.evt_valid), 0);
    step(1);
    chk("t6_rpt1", int'(evt_if.evt_valid), 1);
    chk("t6_rpt1_code", int'(evt_if.evt_code), 3);
    pop_one();
    goto(56);
    chk("t6_no_rpt2_yet", int'(evt_if.evt_valid), 0);
    step(1);
    chk("t6_rpt2", int'(evt_if.evt_valid), 1);
    goto(60);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(evt_if.evt_valid), 0);
    chk("t6_rst_state", int'(btn_state), 0);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
